// File: rtl/fixpoint_iter_checker.sv
// fixpoint_iter_checker
// Loads an initial global state of NPROC token-ring processes and applies the
// transition relation one step per clock. Every step it checks mutual exclusion
// (at most one process in CRIT). The run stops on a fixpoint, a violation, or
// when MAX_ITER steps have been applied. Results hold until the next start.
//
// Optional feature macro: FPC_CONTINUE_ON_VIOLATION_EN
//   undefined : a violation ends the run immediately, with no step applied
//   defined   : violation is sticky and the run continues to fixpoint or bound
//
// Ports
//   clk, rst    clock (rising edge), synchronous active-high reset
//   start       one-cycle run request, accepted only when idle
//   init_state  initial process states, process i at bits [2i+1:2i]
//   init_token  initial token owner (values >= NPROC load as 0)
//   en_mask     per-process step enable
//   busy        run in progress (S_RUN and S_FIN)
//   done        one-cycle completion pulse
//   fixpoint    run ended because the next state equals the current state
//   violation   more than one process was seen in CRIT
//   iter_count  number of steps applied
//   state_out   current global process state (token is not exported)
module fixpoint_iter_checker #(
    parameter int unsigned NPROC    = 3,
    parameter int unsigned MAX_ITER = 16,
    localparam int unsigned TW = (NPROC > 1) ? $clog2(NPROC) : 1,
    localparam int unsigned IW = $clog2(MAX_ITER + 1),
    localparam int unsigned SW = 2 * NPROC
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [SW-1:0] init_state,
    input  logic [TW-1:0] init_token,
    input  logic [NPROC-1:0] en_mask,
    output logic          busy,
    output logic          done,
    output logic          fixpoint,
    output logic          violation,
    output logic [IW-1:0] iter_count,
    output logic [SW-1:0] state_out
);

    localparam logic [1:0] P_IDLE = 2'd0;
    localparam logic [1:0] P_WAIT = 2'd1;
    localparam logic [1:0] P_CRIT = 2'd2;
    localparam logic [1:0] P_DONE = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } fsm_t;

    fsm_t             fsm;
    logic [TW-1:0]    token;
    logic [NPROC-1:0] mask;

    logic [SW-1:0]    next_state;
    logic [TW-1:0]    next_token;
    logic             owner_done;
    logic [3:0]       crit_cnt;
    logic             multi_crit;
    logic             at_fixpoint;
    logic [IW-1:0]    iter_inc;

    // Next global state, CRIT population and fixpoint detection
    always_comb begin
        next_state = state_out;
        owner_done = 1'b0;
        crit_cnt   = 4'd0;
        for (int i = 0; i < int'(NPROC); i++) begin
            if (state_out[2*i +: 2] == P_CRIT) begin
                crit_cnt = crit_cnt + 4'd1;
            end
            if (mask[i]) begin
                case (state_out[2*i +: 2])
                    P_IDLE: next_state[2*i +: 2] = P_WAIT;
                    P_WAIT: next_state[2*i +: 2] = (token == TW'(i)) ? P_CRIT : P_WAIT;
                    P_CRIT: next_state[2*i +: 2] = P_DONE;
                    default: begin
                        next_state[2*i +: 2] = P_IDLE;
                        // token passes only when its owner leaves DONE
                        if (token == TW'(i)) begin
                            owner_done = 1'b1;
                        end
                    end
                endcase
            end
        end
        next_token = token;
        if (owner_done) begin
            next_token = (token == TW'(NPROC - 1)) ? TW'(0) : token + TW'(1);
        end
        multi_crit  = (crit_cnt > 4'd1);
        at_fixpoint = (next_state == state_out) && (next_token == token);
        iter_inc    = iter_count + IW'(1);
    end

    // Control FSM and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm        <= S_IDLE;
            token      <= '0;
            mask       <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            fixpoint   <= 1'b0;
            violation  <= 1'b0;
            iter_count <= '0;
            state_out  <= '0;
        end else begin
            done <= 1'b0;
            case (fsm)
                S_IDLE: begin
                    if (start) begin
                        state_out  <= init_state;
                        token      <= (32'(init_token) >= NPROC) ? TW'(0) : init_token;
                        mask       <= en_mask;
                        iter_count <= '0;
                        fixpoint   <= 1'b0;
                        violation  <= 1'b0;
                        busy       <= 1'b1;
                        fsm        <= S_RUN;
                    end
                end
                S_RUN: begin
`ifdef FPC_CONTINUE_ON_VIOLATION_EN
                    if (multi_crit) begin
                        violation <= 1'b1;
                    end
                    if (at_fixpoint) begin
                        fixpoint <= 1'b1;
                        done     <= 1'b1;
                        fsm      <= S_FIN;
                    end else begin
                        state_out  <= next_state;
                        token      <= next_token;
                        iter_count <= iter_inc;
                        if (iter_inc == IW'(MAX_ITER)) begin
                            done <= 1'b1;
                            fsm  <= S_FIN;
                        end
                    end
`else
                    if (multi_crit) begin
                        violation <= 1'b1;
                        done      <= 1'b1;
                        fsm       <= S_FIN;
                    end else if (at_fixpoint) begin
                        fixpoint <= 1'b1;
                        done     <= 1'b1;
                        fsm      <= S_FIN;
                    end else begin
                        state_out  <= next_state;
                        token      <= next_token;
                        iter_count <= iter_inc;
                        if (iter_inc == IW'(MAX_ITER)) begin
                            done <= 1'b1;
                            fsm  <= S_FIN;
                        end
                    end
`endif
                end
                S_FIN: begin
                    busy <= 1'b0;
                    fsm  <= S_IDLE;
                end
                default: begin
                    busy <= 1'b0;
                    fsm  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fixpoint_iter_checker.sv
// Self-checking bench for fixpoint_iter_checker: directed scenarios plus random
// runs, each compared against a behavioural token-ring model.
module tb_fixpoint_iter_checker;

    localparam int unsigned NPROC    = 3;
    localparam int unsigned MAX_ITER = 16;
    localparam int unsigned TW = 2;
    localparam int unsigned IW = 5;
    localparam int unsigned SW = 2 * NPROC;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [SW-1:0]    init_state = '0;
    logic [TW-1:0]    init_token = '0;
    logic [NPROC-1:0] en_mask = '0;
    logic             busy, done, fixpoint, violation;
    logic [IW-1:0]    iter_count;
    logic [SW-1:0]    state_out;

    int checks = 0;
    int errors = 0;

    // model results
    int            m_fp, m_viol, m_iter, m_cycles;
    logic [SW-1:0] m_traj [0:MAX_ITER];

    fixpoint_iter_checker #(.NPROC(NPROC), .MAX_ITER(MAX_ITER)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .init_state (init_state),
        .init_token (init_token),
        .en_mask    (en_mask),
        .busy       (busy),
        .done       (done),
        .fixpoint   (fixpoint),
        .violation  (violation),
        .iter_count (iter_count),
        .state_out  (state_out)
    );

    always #5 clk = ~clk;

    // Behavioural model: processes as ints, one loop pass per step
    task automatic model(input logic [SW-1:0] is, input int tok_in, input logic [NPROC-1:0] m);
        int p [NPROC];
        int nx [NPROC];
        int tok, ntok, crit;
        bit same, ended_early;
        tok = (tok_in >= int'(NPROC)) ? 0 : tok_in;
        for (int i = 0; i < int'(NPROC); i++) p[i] = int'(is[2*i +: 2]);
        m_fp = 0; m_viol = 0; m_iter = 0; ended_early = 0;
        m_traj[0] = is;
        for (int k = 1; k <= int'(MAX_ITER); k++) m_traj[k] = '0;
        while (1) begin
            crit = 0;
            for (int i = 0; i < int'(NPROC); i++) if (p[i] == 2) crit++;
            if (crit > 1) begin
                m_viol = 1;
`ifndef FPC_CONTINUE_ON_VIOLATION_EN
                ended_early = 1;
                break;
`endif
            end
            for (int i = 0; i < int'(NPROC); i++) begin
                if (!m[i]) nx[i] = p[i];
                else if (p[i] == 1) nx[i] = (tok == i) ? 2 : 1;
                else nx[i] = (p[i] + 1) % 4;
            end
            ntok = (m[tok] && p[tok] == 3) ? (tok + 1) % int'(NPROC) : tok;
            same = (ntok == tok);
            for (int i = 0; i < int'(NPROC); i++) if (nx[i] != p[i]) same = 0;
            if (same) begin
                m_fp = 1;
                ended_early = 1;
                break;
            end
            p = nx;
            tok = ntok;
            m_iter++;
            for (int i = 0; i < int'(NPROC); i++) m_traj[m_iter][2*i +: 2] = 2'(p[i]);
            if (m_iter == int'(MAX_ITER)) break;
        end
        m_cycles = ended_early ? m_iter + 1 : m_iter;
    endtask

    // Start a run, follow it cycle by cycle and compare against the model
    task automatic run_check(input string name, input logic [SW-1:0] is, input logic [TW-1:0] tok,
                             input logic [NPROC-1:0] m, input bit extra,
                             output int a_fp, output int a_viol, output int a_iter, output int a_cyc);
        int cyc;
        logic [SW-1:0] exp_st;
        model(is, int'(tok), m);
        @(negedge clk);
        init_state = is; init_token = tok; en_mask = m; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        init_state = SW'($urandom); init_token = TW'($urandom); en_mask = NPROC'($urandom);
        cyc = 0;
        while (1) begin
            exp_st = m_traj[(cyc < m_iter) ? cyc : m_iter];
            checks++;
            if (state_out !== exp_st) begin
                errors++;
                $display("FAIL %s state_out cycle %0d got %h exp %h", name, cyc, state_out, exp_st);
            end
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL %s busy cycle %0d got %b exp 1", name, cyc, busy);
            end
            if (done === 1'b1) break;
            if (cyc > int'(MAX_ITER) + 4) begin
                errors++;
                $display("FAIL %s timeout waiting for done after %0d cycles", name, cyc);
                break;
            end
            if (extra && cyc == 1) begin
                start = 1'b1;
                init_state = SW'($urandom); en_mask = NPROC'($urandom);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        a_fp = int'(fixpoint); a_viol = int'(violation); a_iter = int'(iter_count); a_cyc = cyc;
        checks++;
        if (cyc != m_cycles) begin
            errors++;
            $display("FAIL %s latency got %0d exp %0d", name, cyc, m_cycles);
        end
        checks++;
        if (fixpoint !== 1'(m_fp) || violation !== 1'(m_viol)) begin
            errors++;
            $display("FAIL %s flags got fp=%b viol=%b exp fp=%0d viol=%0d", name, fixpoint, violation, m_fp, m_viol);
        end
        checks++;
        if (iter_count !== IW'(m_iter)) begin
            errors++;
            $display("FAIL %s iter_count got %0d exp %0d", name, iter_count, m_iter);
        end
        // extra start presented during S_FIN must also be dropped
        if (extra) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s post-done got done=%b busy=%b exp 0 0", name, done, busy);
        end
        checks++;
        if (fixpoint !== 1'(m_fp) || iter_count !== IW'(m_iter) || state_out !== m_traj[m_iter]) begin
            errors++;
            $display("FAIL %s hold got fp=%b iter=%0d st=%h exp fp=%0d iter=%0d st=%h", name,
                     fixpoint, iter_count, state_out, m_fp, m_iter, m_traj[m_iter]);
        end
        if (extra) begin
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                checks++;
                if (done !== 1'b0 || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL %s extra run got done=%b busy=%b exp 0 0", name, done, busy);
                end
            end
        end
    endtask

    task automatic test_reset();
        int fp, vi, it, cy;
        @(negedge clk);
        checks++;
        if (busy !== 0 || done !== 0 || fixpoint !== 0 || violation !== 0 || iter_count !== 0 || state_out !== 0) begin
            errors++;
            $display("FAIL reset_values got busy=%b done=%b fp=%b viol=%b iter=%0d st=%h exp all 0",
                     busy, done, fixpoint, violation, iter_count, state_out);
        end
        rst = 1'b0;
        // mid-run reset after 5 steps
        init_state = '0; init_token = '0; en_mask = '1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (iter_count !== IW'(5)) begin
            errors++;
            $display("FAIL reset_midrun_pre iter_count got %0d exp 5", iter_count);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (busy !== 0 || done !== 0 || iter_count !== 0 || state_out !== 0 || fixpoint !== 0 || violation !== 0) begin
            errors++;
            $display("FAIL reset_midrun got busy=%b done=%b iter=%0d st=%h exp 0 0 0 0", busy, done, iter_count, state_out);
        end
        run_check("reset_rerun", '0, '0, '1, 1'b0, fp, vi, it, cy);
    endtask

    task automatic test_fixpoint();
        int fp, vi, it, cy;
        run_check("fix_nomask", 6'h27, 2'd1, 3'b000, 1'b0, fp, vi, it, cy);
        checks++;
        if (fp != 1 || it != 0 || cy != 1) begin
            errors++;
            $display("FAIL fix_nomask got fp=%0d iter=%0d cyc=%0d exp 1 0 1", fp, it, cy);
        end
        run_check("fix_allwait", 6'h15, 2'd2, 3'b011, 1'b0, fp, vi, it, cy);
        checks++;
        if (fp != 1 || vi != 0 || it != 0) begin
            errors++;
            $display("FAIL fix_allwait got fp=%0d viol=%0d iter=%0d exp 1 0 0", fp, vi, it);
        end
    endtask

    task automatic test_bound();
        int fp, vi, it, cy;
        model('0, 0, '1);
        checks++;
        if (m_traj[2] !== 6'h16) begin
            errors++;
            $display("FAIL bound_step2 model state got %h exp 16", m_traj[2]);
        end
        run_check("bound", '0, '0, '1, 1'b0, fp, vi, it, cy);
        checks++;
        if (fp != 0 || vi != 0 || it != 16 || cy != 16) begin
            errors++;
            $display("FAIL bound got fp=%0d viol=%0d iter=%0d cyc=%0d exp 0 0 16 16", fp, vi, it, cy);
        end
    endtask

    task automatic test_violation();
        int fp, vi, it, cy;
        run_check("violation", 6'h0A, '0, '1, 1'b0, fp, vi, it, cy);
        checks++;
`ifdef FPC_CONTINUE_ON_VIOLATION_EN
        if (vi != 1 || it != 16) begin
            errors++;
            $display("FAIL violation got viol=%0d iter=%0d exp 1 16", vi, it);
        end
`else
        if (vi != 1 || fp != 0 || it != 0) begin
            errors++;
            $display("FAIL violation got viol=%0d fp=%0d iter=%0d exp 1 0 0", vi, fp, it);
        end
`endif
    endtask

    task automatic test_back_to_back();
        int fp, vi, it, cy;
        run_check("b2b_long", '0, '0, '1, 1'b1, fp, vi, it, cy);
        run_check("b2b_short", 6'h15, 2'd2, 3'b011, 1'b1, fp, vi, it, cy);
        run_check("b2b_viol", 6'h0A, 2'd1, 3'b101, 1'b1, fp, vi, it, cy);
    endtask

    task automatic test_random();
        int fp, vi, it, cy;
        for (int n = 0; n < 40; n++) begin
            run_check("random", SW'($urandom), TW'($urandom_range(0, 3)), NPROC'($urandom),
                      1'($urandom), fp, vi, it, cy);
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        test_reset();
        test_fixpoint();
        test_bound();
        test_violation();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
